// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline-boundary skid stages: state encoding
// and the payload widths used at each boundary.
package pipe_stage_skid_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int DEF_CTRL_W = 12;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_CNT_W  = 16;

  typedef struct packed {
    logic [15:0] ctrl_w;
    logic [15:0] data_w;
  } bnd_cfg_t;

  // Per-boundary payload widths (control bits, data bits).
  localparam bnd_cfg_t IFID_CFG  = '{ctrl_w: 16'd2,  data_w: 16'd64};
  localparam bnd_cfg_t IDEX_CFG  = '{ctrl_w: 16'd12, data_w: 16'd128};
  localparam bnd_cfg_t EXMEM_CFG = '{ctrl_w: 16'd6,  data_w: 16'd101};
  localparam bnd_cfg_t MEMWB_CFG = '{ctrl_w: 16'd3,  data_w: 16'd69};

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)                    cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline register: in_ready depends only on registered
// state, so there is no combinational path from out_ready to in_ready.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [1:0]        state;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_ready_q;
  logic              xin, xout;

  assign xin  = in_valid & in_ready_q;
  assign xout = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      // Data entries are left as-is; only control is scrubbed on redirect.
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (xin) begin
          main_ctrl <= in_ctrl;
          main_data <= in_data;
          state     <= ST_ONE;
        end
        ST_ONE: begin
          if (xin && xout) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (xout) begin
            state <= ST_EMPTY;
          end else if (xin) begin
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            state      <= ST_FULL;
            in_ready_q <= 1'b0;
          end
        end
        ST_FULL: if (xout) begin
          main_ctrl  <= skid_ctrl;
          main_data  <= skid_data;
          state      <= ST_ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state      <= ST_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state != ST_EMPTY);
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (~rstn),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a queue-based FIFO model predicts
// every output; directed scenarios plus a long random run.
module tb_pipe_stage_skid;

  localparam int CW = 12;
  localparam int DW = 128;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } item_t;

  logic          clk = 1'b0;
  logic          rstn, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, in_ready_s, out_valid_s;
  logic [CW-1:0] out_ctrl, out_ctrl_s;
  logic [DW-1:0] out_data, out_data_s;
  logic [15:0]   stall_cnt;
  logic [2:0]    stall_cnt_s;

  int errors = 0;
  int checks = 0;

  item_t       q[$];
  logic [DW-1:0] exp_data = '0;
  int          scnt = 0, scnt3 = 0;
  bit          armed = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(3)) dut_s (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_ctrl(out_ctrl_s), .out_data(out_data_s),
    .stall_cnt(stall_cnt_s)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor + reference model: compare at the falling edge, then advance
  // the model to what the next rising edge should produce.
  always @(negedge clk) begin
    if (armed) begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_ctrl", out_ctrl, (q.size() != 0) ? q[0].ctrl : '0);
      chk("out_data", out_data, exp_data);
      chk("stall_cnt", stall_cnt, scnt);
      chk("stall_cnt_w3", stall_cnt_s, scnt3);
    end
    if (!rstn) begin
      q.delete();
      scnt = 0; scnt3 = 0; exp_data = '0;
      armed = 1;
    end else if (armed) begin
      if (q.size() != 0 && !out_ready) begin
        if (scnt < 65535) scnt++;
        if (scnt3 < 7) scnt3++;
      end
      if (flush) q.delete();
      else begin
        bit was_full;
        was_full = (q.size() >= 2);
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && !was_full) q.push_back('{ctrl: in_ctrl, data: in_data});
      end
    end
    if (q.size() != 0) exp_data = q[0].data;
  end

  task automatic step(input bit v, input logic [CW-1:0] c, input bit ordy, input bit fl, input bit rn);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    out_ready = ordy;
    flush     = fl;
    rstn      = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_ctrl", out_ctrl, '0);
    chk("reset_out_data", out_data, '0);
    chk("reset_stall_cnt", stall_cnt, '0);

    // Stream 1,2,3 back-to-back
    step(1, 12'd1, 1, 0, 1); chk("stream_1", out_ctrl, 12'd1);
    step(1, 12'd2, 1, 0, 1); chk("stream_2", out_ctrl, 12'd2); chk("stream_rdy", in_ready, 1'b1);
    step(1, 12'd3, 1, 0, 1); chk("stream_3", out_ctrl, 12'd3); chk("stream_rdy3", in_ready, 1'b1);
    step(0, '0, 1, 0, 1);    chk("stream_drain", out_valid, 1'b0);

    // Stall with A in main, offer B then C
    do_reset();
    step(1, 12'hA, 0, 0, 1);
    step(1, 12'hB, 0, 0, 1); chk("stall_inrdy_low", in_ready, 1'b0);
    step(1, 12'hC, 0, 0, 1);
    step(1, 12'hC, 0, 0, 1); chk("stall_cnt_3", stall_cnt, 16'd3);
    chk("stall_hold_A", out_ctrl, 12'hA);
    step(1, 12'hC, 1, 0, 1); chk("stall_order_B", out_ctrl, 12'hB);
    step(1, 12'hC, 1, 0, 1); chk("stall_order_C", out_ctrl, 12'hC);
    step(0, '0, 1, 0, 1);    chk("stall_drained", out_valid, 1'b0);

    // Flush in FULL with a same-cycle offer of D
    do_reset();
    step(1, 12'hA, 0, 0, 1);
    step(1, 12'hB, 0, 0, 1);
    step(1, 12'hD, 0, 1, 1);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ctrl", out_ctrl, '0);
    chk("flush_inrdy", in_ready, 1'b1);
    repeat (3) step(0, '0, 1, 0, 1);

    // Saturation of the 3-bit counter
    do_reset();
    step(1, 12'h5, 0, 0, 1);
    repeat (10) step(0, '0, 0, 0, 1);
    chk("sat_7", stall_cnt_s, 3'd7);
    chk("sat_wide_10", stall_cnt, 16'd10);
    repeat (2) step(0, '0, 0, 0, 1);
    chk("sat_hold_7", stall_cnt_s, 3'd7);
    step(0, '0, 1, 0, 1);

    // Reset while FULL and stalled
    step(1, 12'h11, 0, 0, 1);
    step(1, 12'h22, 0, 0, 1);
    step(1, 12'h33, 0, 1, 0);
    chk("rst_stall_cnt", stall_cnt, '0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_inrdy", in_ready, 1'b1);
    repeat (3) step(0, '0, 1, 0, 1);

    // Random traffic
    repeat (10000)
      step($urandom_range(99) < 30, CW'($urandom), $urandom_range(99) < 70,
           $urandom_range(99) < 5, 1);
    repeat (4) step(0, '0, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
